// File: rtl/pixel_point_proc.sv
// Point-processing engine: sweeps an IMG_W x IMG_H image out of a source SRAM,
// applies one per-pixel operation and writes the result to a destination SRAM.
module pixel_point_proc #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ADDR_SZ = 16,
  parameter int PIX_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [7:0]         param_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               src_en_o,
  output logic               src_we_o,
  output logic [ADDR_SZ-1:0] src_addr_o,
  input  logic [PIX_W-1:0]   src_data_i,
  output logic               dst_en_o,
  output logic               dst_we_o,
  output logic [ADDR_SZ-1:0] dst_addr_o,
  output logic [PIX_W-1:0]   dst_data_o
);

  localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'(IMG_W * IMG_H - 1);
  localparam logic [PIX_W-1:0]   PIX_MAX   = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               drain_q, drain_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         param_q, param_d;
  logic [ADDR_SZ-1:0] src_addr_q, src_addr_d;

  logic               vld_p1_q;
  logic [ADDR_SZ-1:0] addr_p1_q;
  logic               vld_p2_q;
  logic [ADDR_SZ-1:0] addr_p2_q;
  logic [PIX_W-1:0]   pix_p2_q;

  // Zero-extended pixel plus sign-extended offset, clamped to [0, PIX_MAX].
  function automatic logic [PIX_W-1:0] sat_offset(input logic [PIX_W-1:0] p,
                                                  input logic [7:0]       off);
    logic signed [PIX_W+1:0] sum;
    sum = $signed({2'b00, p}) + $signed({{(PIX_W-6){off[7]}}, off});
    if (sum[PIX_W+1])
      return '0;
    else if (sum > $signed({2'b00, PIX_MAX}))
      return PIX_MAX;
    else
      return sum[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] pix_op(input logic [1:0]       md,
                                              input logic [7:0]       prm,
                                              input logic [PIX_W-1:0] p);
    case (md)
      2'd0:    return p;
      2'd1:    return sat_offset(p, prm);
      2'd2:    return PIX_MAX - p;
      default: return (p >= PIX_W'(prm)) ? PIX_MAX : '0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    mode_d     = mode_q;
    param_d    = param_q;
    src_addr_d = src_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          mode_d     = mode_i;
          param_d    = param_i;
          src_addr_d = '0;
        end
      end
      S_RUN: begin
        // Explicit end compare so a full 2**ADDR_SZ image never relies on wrap.
        if (src_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          src_addr_d = src_addr_q + ADDR_SZ'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      drain_q    <= 1'b0;
      mode_q     <= 2'd0;
      param_q    <= 8'd0;
      src_addr_q <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      addr_p2_q  <= '0;
      pix_p2_q   <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      mode_q     <= mode_d;
      param_q    <= param_d;
      src_addr_q <= src_addr_d;
      // p1: source data returns for the read issued last cycle
      vld_p1_q   <= (state_q == S_RUN);
      // p2: processed pixel registered as the destination write
      vld_p2_q   <= vld_p1_q;
      if (vld_p1_q) begin
        addr_p2_q <= addr_p1_q;
        pix_p2_q  <= pix_op(mode_q, param_q, src_data_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    addr_p1_q <= src_addr_q;
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign src_en_o   = (state_q == S_RUN);
  assign src_we_o   = 1'b0;
  assign src_addr_o = src_addr_q;
  assign dst_en_o   = vld_p2_q;
  assign dst_we_o   = vld_p2_q;
  assign dst_addr_o = addr_p2_q;
  assign dst_data_o = pix_p2_q;

endmodule

// File: tb/tb_pixel_point_proc.sv
// Bench for pixel_point_proc: a 4x4 instance driven by directed sweeps and
// checked every cycle against a timing/arithmetic model, plus a 256x256 pass sweep.
module tb_pixel_point_proc;

  localparam int N  = 16;
  localparam int NB = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  mode;
  logic [7:0]  param;
  logic        busy, done, src_en, src_we, dst_en, dst_we;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  src_data, dst_data;

  logic        rstB, startB;
  logic        busyB, doneB, src_enB, src_weB, dst_enB, dst_weB;
  logic [15:0] src_addrB, dst_addrB;
  logic [7:0]  src_dataB, dst_dataB;

  pixel_point_proc #(.IMG_W(4), .IMG_H(4), .ADDR_SZ(16), .PIX_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .param_i(param),
    .busy_o(busy), .done_o(done), .src_en_o(src_en), .src_we_o(src_we),
    .src_addr_o(src_addr), .src_data_i(src_data), .dst_en_o(dst_en),
    .dst_we_o(dst_we), .dst_addr_o(dst_addr), .dst_data_o(dst_data)
  );

  pixel_point_proc #(.IMG_W(256), .IMG_H(256), .ADDR_SZ(16), .PIX_W(8)) u_big (
    .clk_i(clk), .rst_i(rstB), .start_i(startB), .mode_i(2'd0), .param_i(8'd0),
    .busy_o(busyB), .done_o(doneB), .src_en_o(src_enB), .src_we_o(src_weB),
    .src_addr_o(src_addrB), .src_data_i(src_dataB), .dst_en_o(dst_enB),
    .dst_we_o(dst_weB), .dst_addr_o(dst_addrB), .dst_data_o(dst_dataB)
  );

  // SRAM models: read data one cycle after the request, writes on the edge.
  logic [7:0] srcA [N];
  logic [7:0] dstA [N];
  logic [7:0] dstB [NB];

  always @(posedge clk) begin
    if (src_en) src_data <= srcA[src_addr[3:0]];
    if (dst_en && dst_we) dstA[dst_addr[3:0]] <= dst_data;
    if (src_enB) src_dataB <= src_addrB[7:0];
    if (dst_enB && dst_weB) dstB[dst_addrB] <= dst_dataB;
  end

  int total = 0;
  int bad   = 0;

  int m_act = 0, m_c = 0, m_mode = 0, m_param = 0, m_post = 0;
  int b_run = 0, b_c = 0, b_wr = 0, b_last = 0, b_late0 = 0;
  int b_done_n = 0, b_done_c = -1, b_srcwe = 0;

  int tbl_mix [N] = '{200, 30, 100, 0, 90, 127, 128, 255, 50, 49, 206, 205, 1, 254, 77, 160};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_op(input int md, input int pr, input int p);
    int s;
    case (md)
      0: return p;
      1: begin
        s = p + ((pr >= 128) ? pr - 256 : pr);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
      end
      2: return 255 - p;
      default: return (p >= pr) ? 255 : 0;
    endcase
  endfunction

  // Expected outputs of the 4x4 instance from the cycle index since start.
  task automatic compare_a();
    int e_busy, e_done, e_src, e_dst;
    e_busy = (m_act != 0 && m_c <= N + 2) ? 1 : 0;
    e_done = (m_act != 0 && m_c == N + 3) ? 1 : 0;
    e_src  = (m_act != 0 && m_c <= N) ? 1 : 0;
    e_dst  = (m_act != 0 && m_c >= 3 && m_c <= N + 2) ? 1 : 0;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("src_en", src_en, e_src);
    chk("src_we", src_we, 0);
    chk("dst_en", dst_en, e_dst);
    chk("dst_we", dst_we, e_dst);
    if (e_src != 0) chk("src_addr", src_addr, m_c - 1);
    if (e_dst != 0) begin
      chk("dst_addr", dst_addr, m_c - 3);
      chk("dst_data", dst_data, ref_op(m_mode, m_param, srcA[m_c - 3]));
    end
    if (m_post != 0) begin
      chk("rst_src_addr", src_addr, 0);
      chk("rst_dst_addr", dst_addr, 0);
      chk("rst_dst_data", dst_data, 0);
    end
  endtask

  task automatic monitor_b();
    if (src_weB) b_srcwe++;
    if (b_run != 0) begin
      if (dst_enB && dst_weB) begin
        b_wr++;
        if (dst_addrB == 16'hFFFF) b_last = 1;
        else if (dst_addrB == 16'h0000 && b_last != 0) b_late0 = 1;
      end
      if (doneB) begin
        b_done_n++;
        b_done_c = b_c;
      end
    end
  endtask

  // One clock: advance the models with the inputs this edge samples, then check.
  task automatic tick();
    if (rst) begin
      m_act  = 0;
      m_post = 1;
    end else begin
      m_post = 0;
      if (m_act != 0) begin
        if (m_c == N + 3) m_act = 0;
        else m_c++;
      end else if (start) begin
        m_act   = 1;
        m_c     = 1;
        m_mode  = mode;
        m_param = param;
      end
    end
    if (b_run != 0) b_c++;
    else if (startB && !rstB) begin
      b_run = 1;
      b_c   = 1;
    end
    @(posedge clk);
    #1;
    compare_a();
    monitor_b();
  endtask

  task automatic load_src(input int sel);
    for (int i = 0; i < N; i++)
      case (sel)
        0:       srcA[i] = 8'(i);
        1:       srcA[i] = 8'(tbl_mix[i]);
        default: srcA[i] = 8'(i * 16 + 1);
      endcase
  endtask

  task automatic sweep(input string nm, input int md, input int pr, input int restart_at,
                       input int chg_at, input int chg_md, input int rst_at, input int full);
    int wcnt [N];
    int we_first, we_last, we_n, dn, dcyc, once_bad;
    we_first = -1; we_last = -1; we_n = 0; dn = 0; dcyc = -1; once_bad = 0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    mode  = 2'(md);
    param = 8'(pr);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start = (k == restart_at);
      rst   = (k == rst_at);
      if (k == chg_at) mode = 2'(chg_md);
      if (dst_en && dst_we) begin
        we_n++;
        if (we_first < 0) we_first = k;
        we_last = k;
        if (dst_addr < N) wcnt[dst_addr[3:0]]++;
      end
      if (done) begin
        dn++;
        dcyc = k;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    if (full != 0) begin
      for (int i = 0; i < N; i++) if (wcnt[i] != 1) once_bad++;
      chk({nm, "_done_cyc"}, dcyc, 19);
      chk({nm, "_done_cnt"}, dn, 1);
      chk({nm, "_we_first"}, we_first, 3);
      chk({nm, "_we_last"}, we_last, 18);
      chk({nm, "_we_cnt"}, we_n, 16);
      chk({nm, "_wr_once"}, once_bad, 0);
      for (int i = 0; i < N; i++) chk({nm, "_mem"}, dstA[i], ref_op(md, pr, srcA[i]));
    end else begin
      chk({nm, "_done_cnt"}, dn, 0);
      chk({nm, "_we_last"}, we_last, rst_at);
    end
  endtask

  initial begin
    int errs;
    rst = 1'b1; start = 1'b0; mode = 2'd0; param = 8'd0;
    rstB = 1'b1; startB = 1'b0;
    load_src(0);
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_src_en", src_en, 0);
    chk("reset_dst_we", dst_we, 0);
    chk("reset_dst_data", dst_data, 0);
    rst = 1'b0; rstB = 1'b0; startB = 1'b1;
    tick();
    startB = 1'b0;

    sweep("pass", 0, 0, -1, -1, 0, -1, 1);
    for (int i = 0; i < N; i++) chk("pass_lit", dstA[i], i);

    load_src(1);
    sweep("offp", 1, 100, -1, -1, 0, -1, 1);
    chk("offp_200", dstA[0], 255);
    chk("offp_100", dstA[2], 200);
    chk("offp_255", dstA[7], 255);
    sweep("offn", 1, 8'hCE, -1, -1, 0, -1, 1);
    chk("offn_30", dstA[1], 0);
    chk("offn_100", dstA[2], 50);
    chk("offn_49", dstA[9], 0);
    sweep("inv", 2, 0, -1, -1, 0, -1, 1);
    chk("inv_00", dstA[3], 8'hFF);
    chk("inv_5a", dstA[4], 8'hA5);
    sweep("thr", 3, 128, -1, -1, 0, -1, 1);
    chk("thr_127", dstA[5], 0);
    chk("thr_128", dstA[6], 255);
    chk("thr_255", dstA[7], 255);

    sweep("restart", 2, 128, 5, 6, 3, -1, 1);
    chk("restart_200", dstA[0], 55);
    chk("restart_00", dstA[3], 255);

    sweep("midrst", 1, 5, -1, -1, 0, 8, 0);
    load_src(2);
    sweep("after_rst", 0, 0, -1, -1, 0, -1, 1);
    chk("after_rst_0", dstA[0], 1);
    chk("after_rst_15", dstA[15], 241);

    for (int k = 0; k < 70000 && b_done_n == 0; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    errs = 0;
    for (int i = 0; i < NB; i++) if (dstB[i] != 8'(i)) errs++;
    chk("big_done_cyc", b_done_c, 65539);
    chk("big_done_cnt", b_done_n, 1);
    chk("big_last_wr", b_last, 1);
    chk("big_late0", b_late0, 0);
    chk("big_wr_cnt", b_wr, NB);
    chk("big_mem_err", errs, 0);
    chk("big_busy_end", busyB, 0);
    chk("big_src_we", b_srcwe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
